// File: rtl/hazard_kill_control_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX operand info, redirect and data-memory
// status in; kill, stall and front-end write enables plus statistics counters out.
interface hazard_kill_control_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_valid;
  logic             redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic             control_kill;
  logic             lw_use_stall_control;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] kill_count;

  // Pipeline side drives the status, the controller answers with controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read, ex_valid,
           redirect, dmem_req, dmem_ready,
    input  control_kill, lw_use_stall_control, pc_write_en, ifid_write_en,
           stall_count, kill_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read, ex_valid,
           redirect, dmem_req, dmem_ready,
    output control_kill, lw_use_stall_control, pc_write_en, ifid_write_en,
           stall_count, kill_count
  );
endinterface

// File: rtl/hazard_kill_control.sv
// Load-use stall, post-redirect kill window and data-memory freeze controller.
// Optional macro HAZARD_STATS_EN builds saturating stall/kill statistics counters.
module hazard_kill_control #(
  parameter int KILL_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_kill_control_if.slave bus
);

  typedef enum logic {RUN, KILL} state_t;

  localparam logic [2:0] KILL_RELOAD = 3'(KILL_CYCLES - 1);

  state_t     r_state, w_state_next;
  logic [2:0] r_kill_cnt, w_kill_cnt_next;
  logic       w_hazard, w_freeze, w_kill, w_stall, w_write_en;

  assign w_hazard = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                    ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd)) |
                     (bus.id_uses_rt & (bus.id_rt == bus.ex_rd)));
  assign w_freeze = bus.dmem_req & ~bus.dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_kill_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_kill_cnt <= w_kill_cnt_next;
    end
  end

  // A frozen cycle holds everything, so the window only advances on live cycles.
  always_comb begin
    w_state_next    = r_state;
    w_kill_cnt_next = r_kill_cnt;
    w_kill          = 1'b0;
    if (rst) begin
      w_kill = 1'b1;
    end else if (!w_freeze) begin
      case (r_state)
        RUN: begin
          if (bus.redirect) begin
            w_kill = 1'b1;
            if (KILL_CYCLES > 1) begin
              w_state_next    = KILL;
              w_kill_cnt_next = KILL_RELOAD;
            end
          end
        end
        KILL: begin
          w_kill = 1'b1;
          if (bus.redirect) begin
            w_kill_cnt_next = KILL_RELOAD;
          end else if (r_kill_cnt == 3'd1) begin
            w_state_next    = RUN;
            w_kill_cnt_next = 3'd0;
          end else begin
            w_kill_cnt_next = r_kill_cnt - 3'd1;
          end
        end
        default: begin
          w_state_next    = RUN;
          w_kill_cnt_next = 3'd0;
        end
      endcase
    end
  end

  assign w_stall    = w_hazard & ~w_freeze & ~w_kill & ~rst;
  assign w_write_en = ~rst & ~w_freeze & ~w_stall;

  assign bus.control_kill         = w_kill;
  assign bus.lw_use_stall_control = w_stall;
  assign bus.pc_write_en          = w_write_en;
  assign bus.ifid_write_en        = w_write_en;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_count, r_kill_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_kill_count  <= '0;
    end else begin
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_kill && (r_kill_count != {CNT_W{1'b1}})) begin
        r_kill_count <= r_kill_count + 1'b1;
      end
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.kill_count  = r_kill_count;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
  assign bus.kill_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_kill_control.sv
// Directed scoreboard bench for hazard_kill_control (KILL_CYCLES=2, CNT_W=4).
module tb_hazard_kill_control;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_kill_control_if #(.CNT_W(CNT_W)) bus ();

  hazard_kill_control #(.KILL_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic             kill;
    logic             stall;
    logic             we;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] kc;
  } exp_t;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_failures = 0;
  int   n_cycle    = 0;
  int   m_sc       = 0;
  int   m_kc       = 0;
  bit   m_valid    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n_cycle, got, want);
    end
  endtask

  task automatic idle_inputs();
    rst             = 1'b0;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_uses_rs  = 1'b0;
    bus.id_uses_rt  = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_mem_read = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.redirect    = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt);
    bus.ex_valid    = 1'b1;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = rd;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
  endtask

  // Inputs are already driven; push the expectation, compare at the falling edge,
  // then advance the counter model and move to just after the next rising edge.
  task automatic cyc(input logic k, input logic s, input logic we);
    exp_t e;
    exp_t got;
    e.kill  = k;
    e.stall = s;
    e.we    = we;
`ifdef HAZARD_STATS_EN
    e.sc = CNT_W'(m_sc);
    e.kc = CNT_W'(m_kc);
`else
    e.sc = '0;
    e.kc = '0;
`endif
    q.push_back(e);
    @(negedge clk);
    got = q.pop_front();
    $display("cycle %0d rst=%b redir=%b freeze=%b kill=%b stall=%b pc_we=%b ifid_we=%b sc=%0d kc=%0d",
             n_cycle, rst, bus.redirect, bus.dmem_req & ~bus.dmem_ready, bus.control_kill,
             bus.lw_use_stall_control, bus.pc_write_en, bus.ifid_write_en,
             bus.stall_count, bus.kill_count);
    check("control_kill", 32'(bus.control_kill), 32'(got.kill));
    check("lw_use_stall", 32'(bus.lw_use_stall_control), 32'(got.stall));
    check("pc_write_en", 32'(bus.pc_write_en), 32'(got.we));
    check("ifid_write_en", 32'(bus.ifid_write_en), 32'(got.we));
`ifdef HAZARD_STATS_EN
    if (m_valid) begin
      check("stall_count", 32'(bus.stall_count), 32'(got.sc));
      check("kill_count", 32'(bus.kill_count), 32'(got.kc));
    end
`else
    check("stall_count", 32'(bus.stall_count), 32'(got.sc));
    check("kill_count", 32'(bus.kill_count), 32'(got.kc));
`endif
    if (rst) begin
      m_sc    = 0;
      m_kc    = 0;
      m_valid = 1'b1;
    end else begin
      if (s && m_sc < (2**CNT_W - 1)) m_sc++;
      if (k && m_kc < (2**CNT_W - 1)) m_kc++;
    end
    n_cycle++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset: kill asserted, front end held.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    idle_inputs();
    cyc(1'b0, 1'b0, 1'b1);

    // Load-use on rs, then same with r0 destination, then via rt.
    load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    load_use(5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    load_use(5'd7, 5'd1, 5'd7, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    load_use(5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
    bus.ex_valid = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    load_use(5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
    bus.ex_mem_read = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // Single redirect: exactly two kill cycles, PC still written.
    idle_inputs();
    bus.redirect = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    idle_inputs();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    // Redirect with a simultaneous hazard: kill wins over stall.
    load_use(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
    bus.redirect = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    bus.redirect = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    idle_inputs();
    cyc(1'b0, 1'b0, 1'b1);

    // Freeze inside the window stretches it by the frozen cycles.
    bus.redirect = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    idle_inputs();
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    bus.dmem_ready = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    idle_inputs();
    cyc(1'b0, 1'b0, 1'b1);

    // Redirect under freeze in RUN is ignored.
    bus.redirect = 1'b1;
    bus.dmem_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    idle_inputs();
    cyc(1'b0, 1'b0, 1'b1);

    // Second redirect inside the window reloads it.
    bus.redirect = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    idle_inputs();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    // Reset mid-window aborts it.
    bus.redirect = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    idle_inputs();
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    idle_inputs();
    cyc(1'b0, 1'b0, 1'b1);

    // Hazard held under freeze stalls only once freeze clears.
    load_use(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    bus.dmem_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    bus.dmem_ready = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);

    // Twenty stall cycles saturate the 4-bit stall counter.
    idle_inputs();
    load_use(5'd12, 5'd0, 5'd12, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
    idle_inputs();
    cyc(1'b0, 1'b0, 1'b1);

`ifdef HAZARD_STATS_EN
    check("stall_count_saturated", 32'(bus.stall_count), 32'd15);
`endif
    if (q.size() != 0) check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
